// File: rtl/buffer_swap_ctrl_if.sv
// buffer_swap_ctrl_if: display timing, swap handshake and status bundle for the buffer swap controller
interface buffer_swap_ctrl_if #(parameter int ROW_W = 10);
    logic [ROW_W-1:0] pixel_row;
    logic swap_req;
    logic run_en;
    logic [7:0] frames_per_gen;
    logic clr_ovr;
    logic bram_display;
    logic swap_ack;
    logic gen_tick;
    logic pending;
    logic ovr;
    logic [31:0] gen_count;
    modport master(
        output pixel_row, swap_req, run_en, frames_per_gen, clr_ovr,
        input bram_display, swap_ack, gen_tick, pending, ovr, gen_count
    );
    modport slave(
        input pixel_row, swap_req, run_en, frames_per_gen, clr_ovr,
        output bram_display, swap_ack, gen_tick, pending, ovr, gen_count
    );
endinterface

// File: rtl/buffer_swap_ctrl.sv
// buffer_swap_ctrl: vblank-synchronised double-buffer swap with overrun flag and generation tick
module buffer_swap_ctrl #(
    parameter int V_ACTIVE = 480,
    parameter int ROW_W = 10
) (
    input logic clk,
    input logic reset,
    buffer_swap_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;
    localparam logic [ROW_W-1:0] VROW = ROW_W'(V_ACTIVE);
    state_t state, state_nxt;
    logic [ROW_W-1:0] prev_row;
    logic [7:0] fcnt;
    logic [7:0] fmax;
    logic vsync_evt;
    logic swap_now;
    logic fire;
    assign vsync_evt = bus.pixel_row == VROW && prev_row != VROW;
    assign swap_now = state == PEND && vsync_evt;
    assign fmax = bus.frames_per_gen == 8'd0 ? 8'd1 : bus.frames_per_gen;
    assign fire = {1'b0, fcnt} + 9'd1 >= {1'b0, fmax};
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state == IDLE ? (bus.swap_req ? PEND : IDLE) :
                    state == PEND ? (vsync_evt ? ACK : PEND) :
                    (bus.swap_req ? PEND : IDLE);
    end
    always_comb begin
        bus.swap_ack = state == ACK;
        bus.pending = state == PEND;
    end
    // a request arriving while one is already pending is dropped, even on the vblank edge
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_row <= '0;
            fcnt <= '0;
            bus.bram_display <= 1'b0;
            bus.gen_count <= '0;
            bus.ovr <= 1'b0;
            bus.gen_tick <= 1'b0;
        end else begin
            prev_row <= bus.pixel_row;
            if (swap_now) begin
                bus.bram_display <= ~bus.bram_display;
                bus.gen_count <= bus.gen_count + 32'd1;
            end
            bus.ovr <= (bus.swap_req && state == PEND) || (bus.ovr && !bus.clr_ovr);
            bus.gen_tick <= bus.run_en && vsync_evt && fire;
            fcnt <= !bus.run_en ? 8'd0 : vsync_evt ? (fire ? 8'd0 : fcnt + 8'd1) : fcnt;
        end
    end
endmodule

// File: tb/tb_buffer_swap_ctrl.sv
// tb_buffer_swap_ctrl: directed scenario tests for buffer_swap_ctrl
module tb_buffer_swap_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    buffer_swap_ctrl_if #(.ROW_W(10)) bus();
    buffer_swap_ctrl #(.V_ACTIVE(480), .ROW_W(10)) dut(.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
    endtask

    task automatic row(input int r);
        bus.pixel_row = 10'(r);
        step();
    endtask

    task automatic frame(output logic t0, output logic t1);
        row(0);
        row(480);
        t0 = bus.gen_tick;
        step();
        t1 = bus.gen_tick;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        checks++; if (bus.bram_display !== 1'b0) begin failures++; $display("FAIL reset_bram got=%0b exp=0", bus.bram_display); end
        checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%0b exp=0", bus.pending); end
        checks++; if (bus.swap_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", bus.swap_ack); end
        checks++; if (bus.gen_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b exp=0", bus.gen_tick); end
        checks++; if (bus.ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%0b exp=0", bus.ovr); end
        checks++; if (bus.gen_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.gen_count); end
    endtask

    task automatic test_basic_swap();
        row(100);
        pulse_req();
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL basic_pending got=%0b exp=1", bus.pending); end
        row(479);
        checks++; if (bus.bram_display !== 1'b0) begin failures++; $display("FAIL basic_early_bram got=%0b exp=0", bus.bram_display); end
        row(480);
        checks++; if (bus.bram_display !== 1'b1) begin failures++; $display("FAIL basic_bram got=%0b exp=1", bus.bram_display); end
        checks++; if (bus.gen_count !== 32'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", bus.gen_count); end
        checks++; if (bus.swap_ack !== 1'b1) begin failures++; $display("FAIL basic_ack got=%0b exp=1", bus.swap_ack); end
        checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL basic_pending_clr got=%0b exp=0", bus.pending); end
        step();
        checks++; if (bus.swap_ack !== 1'b0) begin failures++; $display("FAIL basic_ack_once got=%0b exp=0", bus.swap_ack); end
        step();
        step();
        checks++; if (bus.bram_display !== 1'b1) begin failures++; $display("FAIL basic_hold_bram got=%0b exp=1", bus.bram_display); end
    endtask

    task automatic test_simultaneous();
        row(479);
        bus.pixel_row = 10'd480;
        pulse_req();
        checks++; if (bus.bram_display !== 1'b1) begin failures++; $display("FAIL simul_no_toggle got=%0b exp=1", bus.bram_display); end
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL simul_pending got=%0b exp=1", bus.pending); end
        row(0);
        row(100);
        checks++; if (bus.bram_display !== 1'b1) begin failures++; $display("FAIL simul_visible got=%0b exp=1", bus.bram_display); end
        row(480);
        checks++; if (bus.bram_display !== 1'b0) begin failures++; $display("FAIL simul_bram got=%0b exp=0", bus.bram_display); end
        checks++; if (bus.gen_count !== 32'd2) begin failures++; $display("FAIL simul_count got=%0d exp=2", bus.gen_count); end
        checks++; if (bus.swap_ack !== 1'b1) begin failures++; $display("FAIL simul_ack got=%0b exp=1", bus.swap_ack); end
        step();
    endtask

    task automatic test_overrun();
        row(10);
        pulse_req();
        checks++; if (bus.ovr !== 1'b0) begin failures++; $display("FAIL ovr_first got=%0b exp=0", bus.ovr); end
        pulse_req();
        checks++; if (bus.ovr !== 1'b1) begin failures++; $display("FAIL ovr_set got=%0b exp=1", bus.ovr); end
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL ovr_pending got=%0b exp=1", bus.pending); end
        row(480);
        checks++; if (bus.bram_display !== 1'b1) begin failures++; $display("FAIL ovr_bram got=%0b exp=1", bus.bram_display); end
        checks++; if (bus.gen_count !== 32'd3) begin failures++; $display("FAIL ovr_count got=%0d exp=3", bus.gen_count); end
        step();
        checks++; if (bus.ovr !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%0b exp=1", bus.ovr); end
        bus.clr_ovr = 1'b1;
        step();
        bus.clr_ovr = 1'b0;
        checks++; if (bus.ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", bus.ovr); end
        row(10);
        pulse_req();
        bus.clr_ovr = 1'b1;
        pulse_req();
        bus.clr_ovr = 1'b0;
        checks++; if (bus.ovr !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got=%0b exp=1", bus.ovr); end
        bus.clr_ovr = 1'b1;
        step();
        bus.clr_ovr = 1'b0;
        checks++; if (bus.ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear2 got=%0b exp=0", bus.ovr); end
        bus.pixel_row = 10'd480;
        pulse_req();
        checks++; if (bus.ovr !== 1'b1) begin failures++; $display("FAIL ovr_at_vsync got=%0b exp=1", bus.ovr); end
        checks++; if (bus.bram_display !== 1'b0) begin failures++; $display("FAIL ovr_vsync_bram got=%0b exp=0", bus.bram_display); end
        checks++; if (bus.gen_count !== 32'd4) begin failures++; $display("FAIL ovr_vsync_count got=%0d exp=4", bus.gen_count); end
        step();
        checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL ovr_discard got=%0b exp=0", bus.pending); end
        bus.clr_ovr = 1'b1;
        step();
        bus.clr_ovr = 1'b0;
    endtask

    task automatic test_back_to_back();
        row(10);
        pulse_req();
        row(480);
        checks++; if (bus.swap_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack got=%0b exp=1", bus.swap_ack); end
        checks++; if (bus.gen_count !== 32'd5) begin failures++; $display("FAIL b2b_count1 got=%0d exp=5", bus.gen_count); end
        pulse_req();
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL b2b_pending got=%0b exp=1", bus.pending); end
        checks++; if (bus.ovr !== 1'b0) begin failures++; $display("FAIL b2b_no_ovr got=%0b exp=0", bus.ovr); end
        row(10);
        row(480);
        checks++; if (bus.bram_display !== 1'b0) begin failures++; $display("FAIL b2b_bram got=%0b exp=0", bus.bram_display); end
        checks++; if (bus.gen_count !== 32'd6) begin failures++; $display("FAIL b2b_count2 got=%0d exp=6", bus.gen_count); end
        step();
    endtask

    task automatic test_tick_rate();
        logic t0, t1;
        bus.run_en = 1'b1;
        bus.frames_per_gen = 8'd3;
        for (int i = 0; i < 6; i++) begin
            frame(t0, t1);
            checks++; if (t0 !== (i % 3 == 2)) begin failures++; $display("FAIL tick3_f%0d got=%0b exp=%0b", i, t0, i % 3 == 2); end
            checks++; if (t1 !== 1'b0) begin failures++; $display("FAIL tick3_width_f%0d got=%0b exp=0", i, t1); end
        end
        bus.frames_per_gen = 8'd0;
        pulse_req();
        for (int i = 0; i < 3; i++) begin
            frame(t0, t1);
            checks++; if (t0 !== 1'b1) begin failures++; $display("FAIL tick0_f%0d got=%0b exp=1", i, t0); end
        end
        checks++; if (bus.gen_count !== 32'd7) begin failures++; $display("FAIL tick_swap_count got=%0d exp=7", bus.gen_count); end
        bus.run_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame(t0, t1);
            checks++; if (t0 !== 1'b0) begin failures++; $display("FAIL tick_off_f%0d got=%0b exp=0", i, t0); end
        end
        checks++; if (bus.bram_display !== 1'b1) begin failures++; $display("FAIL tick_bram got=%0b exp=1", bus.bram_display); end
    endtask

    task automatic test_reset_mid();
        row(300);
        pulse_req();
        checks++; if (bus.pending !== 1'b1) begin failures++; $display("FAIL rmid_pending got=%0b exp=1", bus.pending); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.bram_display !== 1'b0) begin failures++; $display("FAIL rmid_bram got=%0b exp=0", bus.bram_display); end
        checks++; if (bus.pending !== 1'b0) begin failures++; $display("FAIL rmid_pending_clr got=%0b exp=0", bus.pending); end
        checks++; if (bus.gen_count !== 32'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", bus.gen_count); end
        row(480);
        step();
        checks++; if (bus.bram_display !== 1'b0) begin failures++; $display("FAIL rmid_no_toggle got=%0b exp=0", bus.bram_display); end
        checks++; if (bus.swap_ack !== 1'b0) begin failures++; $display("FAIL rmid_no_ack got=%0b exp=0", bus.swap_ack); end
        checks++; if (bus.gen_count !== 32'd0) begin failures++; $display("FAIL rmid_count2 got=%0d exp=0", bus.gen_count); end
        row(10);
        pulse_req();
        row(480);
        checks++; if (bus.bram_display !== 1'b1) begin failures++; $display("FAIL rmid_first_vsync got=%0b exp=1", bus.bram_display); end
    endtask

    initial begin
        bus.pixel_row = '0;
        bus.swap_req = 1'b0;
        bus.run_en = 1'b0;
        bus.frames_per_gen = 8'd1;
        bus.clr_ovr = 1'b0;
        test_reset();
        test_basic_swap();
        test_simultaneous();
        test_overrun();
        test_back_to_back();
        test_tick_rate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/buffer_swap_ctrl.md
BUFFER_SWAP_CTRL -- requirements
Module: buffer_swap_ctrl

Interface
REQ-001 Parameter: V_ACTIVE, 480, number of visible rows; vblank-start event is pixel_row changing to V_ACTIVE.
REQ-002 Parameter: ROW_W, 10, pixel_row width.
REQ-003 Port: clk  input  1  system clock; the block has one clock.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: pixel_row  input  ROW_W  current display row from the timing generator.
REQ-006 Port: swap_req  input  1  one-cycle pulse from GPIO: back buffer fully written, swap requested.
REQ-007 Port: run_en  input  1  level; 1 = auto-generation ticks enabled.
REQ-008 Port: frames_per_gen  input  8  frames between gen_tick pulses; 0 treated as 1.
REQ-009 Port: clr_ovr  input  1  one-cycle pulse; clears ovr.
REQ-010 Port: bram_display  output  1  selects BRAM displayed (0 = BRAM 0, 1 = BRAM 1); software writes the other.
REQ-011 Port: swap_ack  output  1  one-cycle pulse, cycle after bram_display toggles.
REQ-012 Port: gen_tick  output  1  one-cycle pulse requesting software compute next generation.
REQ-013 Port: pending  output  1  swap requested, not yet applied.
REQ-014 Port: ovr  output  1  sticky: swap_req received while pending.
REQ-015 Port: gen_count  output  32  number of swaps applied since reset, wraps modulo 2^32.

Function
REQ-016 Row tracking SHALL register pixel_row each cycle (prev_row); vsync_evt = (pixel_row == V_ACTIVE) && (prev_row != V_ACTIVE), asserted exactly one cycle per frame.
REQ-017 State machine SHALL have states IDLE, PEND, ACK; pending = (state == PEND).
REQ-018 IDLE: swap_req -> PEND; swap_req coinciding with vsync_evt still -> PEND, swap deferred to the next vsync_evt.
REQ-019 PEND: vsync_evt -> toggle bram_display, increment gen_count, -> ACK, in the same clock edge.
REQ-020 ACK: swap_ack = 1 for this single cycle, unconditional -> IDLE; swap_req in ACK -> PEND (accepted, not overrun).
REQ-021 PEND: swap_req without vsync_evt SHALL set ovr and be discarded (state stays PEND); swap_req coinciding with vsync_evt in PEND SHALL set ovr and be discarded (swap applies once).
REQ-022 ovr SHALL clear only on clr_ovr or reset; clr_ovr and a new overrun in the same cycle -> ovr = 1 (set wins).
REQ-023 bram_display SHALL change only on the edge where vsync_evt and state == PEND, never during visible rows.
REQ-024 Frame counter (8-bit) SHALL increment on each vsync_evt while run_en = 1; when count + 1 >= max(frames_per_gen,1), gen_tick = 1 on the next cycle and counter resets to 0.
REQ-025 run_en = 0 SHALL hold the frame counter at 0 and suppress gen_tick; a frames_per_gen change takes effect at the next vsync_evt comparison.
REQ-026 gen_tick SHALL be independent of swap state (tick may occur while PEND).
REQ-027 gen_count SHALL wrap 0xFFFFFFFF -> 0 without flag.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 reset = 1 SHALL force on the next edge: state IDLE, bram_display 0, swap_ack 0, gen_tick 0, pending 0, ovr 0, gen_count 0, frame counter 0, prev_row 0.
REQ-030 reset mid-PEND SHALL discard the pending swap; first vsync_evt after reset with prev_row = 0 and pixel_row = V_ACTIVE is valid.
REQ-031 reset has priority over every other input in the same cycle.

Verification
REQ-032 Basic swap: reset, swap_req at row 100 -> pending=1; row reaches 480 -> bram_display 0->1, gen_count=1, swap_ack pulse one cycle later, pending=0.
REQ-033 Simultaneous: swap_req in the vsync_evt cycle from IDLE -> no toggle that frame; toggle at the following frame's row-480 edge.
REQ-034 Overrun: two swap_req pulses in one frame -> ovr=1, single toggle at vblank, gen_count +1; clr_ovr -> ovr=0.
REQ-035 Tick rate: run_en=1, frames_per_gen=3 -> gen_tick every 3rd vsync_evt; frames_per_gen=0 -> every vsync_evt; run_en=0 -> none.
REQ-036 Reset mid-operation: pending=1, bram_display=1, reset asserted at row 300 -> all outputs 0, no toggle at next vblank without new swap_req.
